trace_query_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one signal-history query engine between up to NUM_REQ pipeline-stage trackers (IF, ID, EX, WB). Each tracker posts a time-window query (start/end counter values); the arbiter grants one requester at a time, drives the engine's issue handshake, waits for completion, and routes the hit flag and first-match time back to the granted tracker. It sits between the stage trackers and the shared signal tracker history, replacing per-tracker private history buffers.

---
 rtl/trace_query_arbiter_pkg.sv | 16 +
 rtl/trace_query_arbiter_rr_priority_picker.sv | 33 +++
 rtl/trace_query_arbiter.sv | 151 +++++++++++++++
 tb/tb_trace_query_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_query_arbiter_pkg.sv
// Shared types for trace_query_arbiter: FSM state encoding and the no-match time marker.
package trace_query_arbiter_pkg;

  localparam int unsigned MAX_TIME_WIDTH = 64;

  // All-ones marker returned when no hit; truncated to TIME_WIDTH at the use site.
  localparam logic [MAX_TIME_WIDTH-1:0] NO_MATCH = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } trace_query_state_t;

endpackage

// File: rtl/trace_query_arbiter_rr_priority_picker.sv
// Round-robin priority picker: first set request at or after ptr, wrapping.
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic        found;
  int unsigned j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/trace_query_arbiter.sv
// Round-robin sequencer sharing one history query engine among NUM_REQ trackers.
// Optional WAIT timeout enabled by defining TRACE_QUERY_TIMEOUT_EN.
module trace_query_arbiter
  import trace_query_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIME_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*TIME_WIDTH-1:0] req_start,
  input  logic [NUM_REQ*TIME_WIDTH-1:0] req_end,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic                          rsp_hit,
  output logic [TIME_WIDTH-1:0]         rsp_time,
  output logic                          rsp_timeout,
  output logic                          q_issue,
  output logic [TIME_WIDTH-1:0]         q_start,
  output logic [TIME_WIDTH-1:0]         q_end,
  input  logic                          q_done,
  input  logic                          q_hit,
  input  logic [TIME_WIDTH-1:0]         q_time,
  output logic                          busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam logic [TIME_WIDTH-1:0] NO_MATCH_W = TIME_WIDTH'(NO_MATCH);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIME_WIDTH > MAX_TIME_WIDTH || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("trace_query_arbiter: unsupported parameter set");
  end

  trace_query_state_t    state;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      gnt_idx;
  logic [NUM_REQ-1:0]    pick_grant;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic [TIME_WIDTH-1:0] starts [NUM_REQ];
  logic [TIME_WIDTH-1:0] ends   [NUM_REQ];
  logic [TIME_WIDTH-1:0] win_start;
  logic [TIME_WIDTH-1:0] win_end;

`ifdef TRACE_QUERY_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign starts[i] = req_start[i*TIME_WIDTH +: TIME_WIDTH];
    assign ends[i]   = req_end[i*TIME_WIDTH +: TIME_WIDTH];
  end

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign win_start = starts[pick_idx];
  assign win_end   = ends[pick_idx];

  // Accept is offered only while idle, so a grant always lines up with the capture edge.
  assign req_ready = (state == ST_IDLE && !rst) ? pick_grant : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      gnt_idx     <= '0;
      rsp_valid   <= '0;
      rsp_hit     <= 1'b0;
      rsp_time    <= '0;
      rsp_timeout <= 1'b0;
      q_issue     <= 1'b0;
      q_start     <= '0;
      q_end       <= '0;
      busy        <= 1'b0;
`ifdef TRACE_QUERY_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      q_issue   <= 1'b0;
      rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            gnt_idx <= pick_idx;
            rr_ptr  <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            busy    <= 1'b1;
            // Inverted window can never match; answer without touching the engine.
            if (win_start > win_end) begin
              state       <= ST_RESPOND;
              rsp_valid   <= NUM_REQ'(1) << pick_idx;
              rsp_hit     <= 1'b0;
              rsp_time    <= NO_MATCH_W;
              rsp_timeout <= 1'b0;
            end else begin
              state   <= ST_ISSUE;
              q_issue <= 1'b1;
              q_start <= win_start;
              q_end   <= win_end;
            end
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
`ifdef TRACE_QUERY_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (q_done) begin
            state       <= ST_RESPOND;
            rsp_valid   <= NUM_REQ'(1) << gnt_idx;
            rsp_hit     <= q_hit;
            rsp_time    <= q_hit ? q_time : NO_MATCH_W;
            rsp_timeout <= 1'b0;
`ifdef TRACE_QUERY_TIMEOUT_EN
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state       <= ST_RESPOND;
            rsp_valid   <= NUM_REQ'(1) << gnt_idx;
            rsp_hit     <= 1'b0;
            rsp_time    <= NO_MATCH_W;
            rsp_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        ST_RESPOND: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trace_query_arbiter.sv
// Scoreboard bench for trace_query_arbiter: directed transactions, decoupled response monitor.
module tb_trace_query_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned TW = 32;
`ifdef TRACE_QUERY_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 64;
`endif
  localparam logic [TW-1:0] NM = '1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*TW-1:0]  req_start;
  logic [NR*TW-1:0]  req_end;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic              rsp_hit;
  logic [TW-1:0]     rsp_time;
  logic              rsp_timeout;
  logic              q_issue;
  logic [TW-1:0]     q_start;
  logic [TW-1:0]     q_end;
  logic              q_done;
  logic              q_hit;
  logic [TW-1:0]     q_time;
  logic              busy;

  typedef struct {
    logic [NR-1:0] oh;
    logic          hit;
    logic [TW-1:0] tm;
    logic          to;
  } exp_t;

  exp_t sbq[$];
  int   vec  = 0;
  int   miss = 0;

  logic          eng_en  = 1'b1;
  logic          eng_hit = 1'b1;
  logic [TW-1:0] eng_off = '0;

  trace_query_arbiter #(
    .NUM_REQ        (NR),
    .TIME_WIDTH     (TW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_start   (req_start),
    .req_end     (req_end),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_hit     (rsp_hit),
    .rsp_time    (rsp_time),
    .rsp_timeout (rsp_timeout),
    .q_issue     (q_issue),
    .q_start     (q_start),
    .q_end       (q_end),
    .q_done      (q_done),
    .q_hit       (q_hit),
    .q_time      (q_time),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [NR-1:0] oh, input logic hit, input logic [TW-1:0] tm, input logic to);
    exp_t e;
    e.oh = oh; e.hit = hit; e.tm = tm; e.to = to;
    sbq.push_back(e);
  endtask

  task automatic set_win(input int r, input logic [TW-1:0] s, input logic [TW-1:0] e);
    req_start[r*TW +: TW] = s;
    req_end[r*TW +: TW]   = e;
  endtask

  // Engine model: answers every issue one cycle later with hit=eng_hit, time=start+eng_off.
  initial begin
    logic [TW-1:0] s;
    forever begin
      @(negedge clk);
      if (q_issue && eng_en) begin
        s = q_start;
        @(posedge clk);
        #1;
        q_done = 1'b1;
        q_hit  = eng_hit;
        q_time = s + eng_off;
        @(posedge clk);
        #1;
        q_done = 1'b0;
        q_hit  = 1'b0;
        q_time = '0;
      end
    end
  end

  // Response monitor: every strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid !== '0) begin
      vec++;
      if (sbq.size() == 0) begin
        miss++;
        $display("FAIL rsp_unexpected: got valid=%b hit=%b time=%0h to=%b, expected no response",
                 rsp_valid, rsp_hit, rsp_time, rsp_timeout);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (rsp_valid !== e.oh || rsp_hit !== e.hit || rsp_time !== e.tm || rsp_timeout !== e.to) begin
          miss++;
          $display("FAIL rsp_payload: got valid=%b hit=%b time=%0h to=%b, expected valid=%b hit=%b time=%0h to=%b",
                   rsp_valid, rsp_hit, rsp_time, rsp_timeout, e.oh, e.hit, e.tm, e.to);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants;
    int last;
    int c;
    int n;
    rst = 1'b1; req_valid = '0; req_start = '0; req_end = '0;
    q_done = 1'b0; q_hit = 1'b0; q_time = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_busy_issue", {62'd0, busy, q_issue}, 64'd0);
    chk("rst_rsp", {31'd0, rsp_hit, rsp_time}, 64'd0);
    chk("rst_q_win", {q_start, q_end}, 64'd0);
    tick(); rst = 1'b0;

    // Single requester 1, window 10..20, hit at 14.
    tick(); req_valid = 4'b0010; set_win(1, 10, 20); eng_hit = 1'b1; eng_off = 4;
    @(negedge clk); chk("t1_ready", 64'(req_ready), 64'(4'b0010));
    push(4'b0010, 1'b1, 32'd14, 1'b0);
    tick(); req_valid = '0;
    @(negedge clk); chk("t1_issue", {q_issue, busy}, 64'(2'b11));
    chk("t1_qwin", {q_start, q_end}, {32'd10, 32'd20});
    @(negedge clk); chk("t1_no_rsp_early", 64'(rsp_valid), 64'(0));
    @(negedge clk); chk("t1_rsp_latency", 64'(rsp_valid), 64'(4'b0010));
    @(negedge clk); chk("t1_hold", {rsp_hit, rsp_time}, {31'd0, 1'b1, 32'd14});
    chk("t1_idle", {busy, rsp_valid}, 64'(0));

    // Inverted window on requester 2: engine bypassed.
    tick(); req_valid = 4'b0100; set_win(2, 30, 25);
    @(negedge clk); chk("t2_ready", 64'(req_ready), 64'(4'b0100));
    push(4'b0100, 1'b0, NM, 1'b0);
    tick(); req_valid = '0;
    @(negedge clk); chk("t2_no_issue", 64'(q_issue), 64'(0));
    chk("t2_rsp_latency", 64'(rsp_valid), 64'(4'b0100));
    chk("t2_qwin_stable", {q_start, q_end}, {32'd10, 32'd20});
    @(negedge clk);

    // Requester 0 after wrap, engine reports miss with a junk time.
    tick(); req_valid = 4'b0001; set_win(0, 5, 9); eng_hit = 1'b0; eng_off = 2;
    @(negedge clk); chk("t3_ready", 64'(req_ready), 64'(4'b0001));
    push(4'b0001, 1'b0, NM, 1'b0);
    tick(); req_valid = '0;
    repeat (4) @(negedge clk);

    // Reset while waiting on the engine; a stale completion afterwards is ignored.
    eng_en = 1'b0;
    tick(); req_valid = 4'b1000; set_win(3, 40, 60);
    @(negedge clk); chk("t4_ready", 64'(req_ready), 64'(4'b1000));
    tick(); req_valid = '0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("t4_rst_state", {busy, q_issue, rsp_valid}, 64'(0));
    chk("t4_rst_vals", {q_start, rsp_time}, 64'd0);
    tick(); q_done = 1'b1; q_hit = 1'b1; q_time = 3;
    tick(); q_done = 1'b0; q_hit = 1'b0; q_time = '0;
    repeat (3) begin
      @(negedge clk); chk("t4_stale_ignored", {busy, q_issue, rsp_valid, rsp_hit}, 64'(0));
    end
    eng_en = 1'b1;

    // All four requesting from reset: order 0,1,2,3,0 at four-cycle spacing.
    @(negedge clk); rst = 1'b1;
    req_valid = 4'b1111; eng_hit = 1'b1; eng_off = 1;
    for (int i = 0; i < 4; i++) set_win(i, 32'(i*100), 32'(i*100 + 50));
    tick(); rst = 1'b0;
    grants = 0; last = 0; c = 0;
    while (c < 40 && grants < 5) begin
      @(negedge clk); c++;
      if (req_ready !== '0) begin
        chk("rr_grant", 64'(req_ready), 64'(4'b0001 << (grants % 4)));
        if (grants > 0) chk("rr_gap", 64'(c - last), 64'd4);
        push(4'b0001 << (grants % 4), 1'b1, 32'((grants % 4) * 100 + 1), 1'b0);
        last = c;
        grants++;
      end
    end
    chk("rr_count", 64'(grants), 64'd5);
    tick(); req_valid = '0;
    repeat (6) @(negedge clk);

`ifdef TRACE_QUERY_TIMEOUT_EN
    // Engine silent: timeout response after TO cycles in WAIT, late completion dropped.
    eng_en = 1'b0;
    tick(); req_valid = 4'b0010; set_win(1, 1, 2);
    @(negedge clk); chk("to_ready", 64'(req_ready), 64'(4'b0010));
    push(4'b0010, 1'b0, NM, 1'b1);
    tick(); req_valid = '0;
    @(negedge clk);
    n = 0;
    while (n < 40) begin
      @(negedge clk); n++;
      if (rsp_valid !== '0) break;
    end
    chk("to_latency", 64'(n), 64'(TO + 1));
    tick(); q_done = 1'b1; q_hit = 1'b1; q_time = 9;
    tick(); q_done = 1'b0; q_hit = 1'b0;
    repeat (3) begin
      @(negedge clk); chk("to_late_done", {busy, rsp_valid}, 64'(0));
    end
    chk("to_flag_hold", {rsp_timeout, rsp_hit}, 64'(2'b10));
    eng_en = 1'b1;
`else
    n = 0;
`endif

    @(negedge clk);
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
